// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state encoding and plaintext character rules for the RC4 stages.
package rc4_pkg;
  typedef enum logic [3:0] {
    IDLE, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, RD_F, CAP_F, WR_D, DONE, CHECK
  } state_t;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  function automatic logic is_valid_char(input logic [7:0] b);
    return b == ASCII_SPACE || (b >= ASCII_LO && b <= ASCII_HI);
  endfunction
endpackage

// File: rtl/ram_decryptor_if.sv
// ram_decryptor_if: S-RAM, encrypted ROM and decrypted RAM ports of the decryptor.
interface ram_decryptor_if #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_LENGTH = 8,
  parameter int MSG_ADDR_WIDTH = 5
);
  logic [RAM_WIDTH-1:0] ram_out;
  logic [RAM_LENGTH-1:0] address;
  logic [RAM_WIDTH-1:0] ram_in;
  logic write_enable;
  logic [MSG_ADDR_WIDTH-1:0] enc_address;
  logic [RAM_WIDTH-1:0] enc_data;
  logic [MSG_ADDR_WIDTH-1:0] dec_address;
  logic [RAM_WIDTH-1:0] dec_data;
  logic dec_write_enable;
  modport master (
    input ram_out, enc_data,
    output address, ram_in, write_enable, enc_address, dec_address, dec_data, dec_write_enable
  );
  modport slave (
    output ram_out, enc_data,
    input address, ram_in, write_enable, enc_address, dec_address, dec_data, dec_write_enable
  );
endinterface

// File: rtl/trap_edge.sv
// trap_edge: registered one-cycle pulse on each rising edge of a level input.
module trap_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev <= level;
      pulse <= level & ~prev;
    end
  end
endmodule

// File: rtl/ram_decryptor.sv
// ram_decryptor: RC4 PRGA stage; swaps S, forms keystream and writes decrypted bytes.
module ram_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_LENGTH = 8,
  parameter int MSG_LENGTH = 32,
  parameter int MSG_ADDR_WIDTH = 5,
  parameter int CHECK_ASCII = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic finished,
  output logic message_valid,
  ram_decryptor_if.master bus,
  output logic [7:0] iTap,
  output logic [7:0] jTap,
  output logic [MSG_ADDR_WIDTH-1:0] kTap,
  output logic [3:0] stateTap
);
  localparam logic [MSG_ADDR_WIDTH-1:0] K_LAST = MSG_ADDR_WIDTH'(MSG_LENGTH - 1);
  state_t state, nxt;
  logic start_edge, mv_n;
  logic [RAM_LENGTH-1:0] i, j, i_n, j_n, addr_n;
  logic [MSG_ADDR_WIDTH-1:0] k, k_n, enc_addr_n, dec_addr_n;
  logic [RAM_WIDTH-1:0] si, sj, f, enc_byte, si_n, sj_n, f_n, enc_n, ram_in_n, dec_data_n, dec_byte;
  trap_edge u_trap_edge (.clk(clk), .reset(reset), .level(start), .pulse(start_edge));
  assign dec_byte = f ^ enc_byte;
  always_comb begin
    nxt = state;
    i_n = i;
    j_n = j;
    k_n = k;
    si_n = si;
    sj_n = sj;
    f_n = f;
    enc_n = enc_byte;
    mv_n = message_valid;
    case (state)
      IDLE: if (start_edge) begin
        nxt = RD_I;
        i_n = RAM_LENGTH'(1);
        j_n = '0;
        k_n = '0;
        mv_n = 1'b0;
      end
      RD_I: nxt = CAP_I;
      CAP_I: begin
        nxt = RD_J;
        si_n = bus.ram_out;
        j_n = j + bus.ram_out;
      end
      RD_J: nxt = CAP_J;
      CAP_J: begin
        nxt = WR_I;
        sj_n = bus.ram_out;
        enc_n = bus.enc_data;
      end
      WR_I: nxt = WR_J;
      WR_J: nxt = RD_F;
      RD_F: nxt = CAP_F;
      CAP_F: begin
        nxt = WR_D;
        f_n = bus.ram_out;
      end
      WR_D: nxt = CHECK;
      // the byte is already written; decide abort, finish or next byte
      CHECK: if (CHECK_ASCII != 0 && !is_valid_char(dec_byte)) begin
        nxt = DONE;
        mv_n = 1'b0;
      end else if (k == K_LAST) begin
        nxt = DONE;
        mv_n = 1'b1;
      end else begin
        nxt = RD_I;
        k_n = k + 1'b1;
        i_n = i + 1'b1;
      end
      default: nxt = IDLE;
    endcase
    // outputs are registered from the next state so they hold while in that state
    addr_n = (nxt == RD_I || nxt == WR_I) ? i_n :
             (nxt == RD_J || nxt == WR_J) ? j_n :
             (nxt == RD_F) ? si_n + sj_n : bus.address;
    ram_in_n = nxt == WR_I ? sj_n : nxt == WR_J ? si_n : bus.ram_in;
    enc_addr_n = nxt == RD_I ? k_n : bus.enc_address;
    dec_addr_n = nxt == WR_D ? k_n : bus.dec_address;
    dec_data_n = nxt == WR_D ? f_n ^ enc_n : bus.dec_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {i, j, k, si, sj, f, enc_byte} <= '0;
      {finished, message_valid, iTap, jTap, kTap, stateTap} <= '0;
      {bus.address, bus.ram_in, bus.write_enable} <= '0;
      {bus.enc_address, bus.dec_address, bus.dec_data, bus.dec_write_enable} <= '0;
    end else begin
      state <= nxt;
      {i, j, k, si, sj, f, enc_byte} <= {i_n, j_n, k_n, si_n, sj_n, f_n, enc_n};
      finished <= nxt == DONE;
      message_valid <= mv_n;
      iTap <= i_n;
      jTap <= j_n;
      kTap <= k_n;
      stateTap <= nxt;
      bus.address <= addr_n;
      bus.ram_in <= ram_in_n;
      bus.write_enable <= nxt == WR_I || nxt == WR_J;
      bus.enc_address <= enc_addr_n;
      bus.dec_address <= dec_addr_n;
      bus.dec_data <= dec_data_n;
      bus.dec_write_enable <= nxt == WR_D;
    end
  end
endmodule

// File: tb/tb_ram_decryptor.sv
// tb_ram_decryptor: scoreboard bench; two instances (CHECK_ASCII 0 and 1) run the same S/ROM images.
module tb_ram_decryptor;
  localparam int ML = 9;
  logic clk = 0, reset = 1, start = 0;
  always #5 clk = ~clk;
  logic fin[2], mv[2];
  logic [7:0] itap[2], jtap[2];
  logic [4:0] ktap[2];
  logic [3:0] stap[2];
  logic [63:0] outs[2];
  logic [7:0] s_mem[2][256];
  logic [7:0] exp_s[2][256];
  logic [7:0] enc_mem[2][32];
  logic [12:0] exp_wr[2][$];
  int exp_fin[2][$];
  int vectors = 0, errors = 0, cyc = 0, t0 = 0;
  int fin_cnt[2];
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : inst
    ram_decryptor_if #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_ADDR_WIDTH(5)) bus ();
    ram_decryptor #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_LENGTH(ML), .MSG_ADDR_WIDTH(5),
                    .CHECK_ASCII(g)) dut (
      .clk(clk), .reset(reset), .start(start), .finished(fin[g]), .message_valid(mv[g]),
      .bus(bus), .iTap(itap[g]), .jTap(jtap[g]), .kTap(ktap[g]), .stateTap(stap[g]));
    assign outs[g] = {1'b0, fin[g], mv[g], bus.address, bus.ram_in, bus.write_enable,
                      bus.enc_address, bus.dec_address, bus.dec_data, bus.dec_write_enable,
                      itap[g], jtap[g], ktap[g], stap[g]};
    always @(posedge clk) begin
      bus.ram_out <= s_mem[g][bus.address];
      bus.enc_data <= enc_mem[g][bus.enc_address];
      if (bus.write_enable) s_mem[g][bus.address] = bus.ram_in;
    end
    always @(negedge clk) if (!reset) begin
      if (bus.dec_write_enable) begin
        vectors++;
        if (exp_wr[g].size() == 0) begin
          errors++;
          $display("FAIL dec_write[%0d]: got addr %0d data %h, expected no write", g,
                   bus.dec_address, bus.dec_data);
        end else begin
          logic [12:0] e;
          e = exp_wr[g].pop_front();
          if ({bus.dec_address, bus.dec_data} !== e) begin
            errors++;
            $display("FAIL dec_write[%0d]: got addr %0d data %h, expected addr %0d data %h", g,
                     bus.dec_address, bus.dec_data, e[12:8], e[7:0]);
          end
        end
      end
      if (fin[g]) begin
        int act;
        fin_cnt[g]++;
        vectors++;
        act = (mv[g] ? 1000 : 0) + cyc - t0 - 1;
        if (exp_fin[g].size() == 0) begin
          errors++;
          $display("FAIL finished[%0d]: got valid*1000+latency %0d, expected no finish", g, act);
        end else begin
          int e;
          e = exp_fin[g].pop_front();
          if (act != e) begin
            errors++;
            $display("FAIL finished[%0d]: got valid*1000+latency %0d, expected %0d", g, act, e);
          end
        end
      end
    end
  end

  function automatic logic [7:0] lc();
    return $urandom_range(0, 26) == 26 ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
  endfunction

  task automatic load(input int mode);
    logic [7:0] s[256], key[3], t;
    int j = 0, r;
    key = '{8'h4B, 8'h65, 8'h79};
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      if (mode == 1) r = $urandom_range(x, 255);
      else if (mode == 2) begin
        j = (j + s[x] + key[x % 3]) % 256;
        r = j;
      end else r = x;
      t = s[x]; s[x] = s[r]; s[r] = t;
    end
    for (int g = 0; g < 2; g++) begin
      for (int x = 0; x < 256; x++) s_mem[g][x] = s[x];
      for (int k = 0; k < 32; k++) enc_mem[g][k] = 8'($urandom);
    end
  endtask

  // reference RC4 PRGA over a copy of S; optionally rewrites the ROM so the plaintext is lowercase
  task automatic plan(input int g, input bit lower, input bit push);
    logic [7:0] s[256], t, f, d;
    int i = 0, j = 0;
    for (int x = 0; x < 256; x++) s[x] = s_mem[g][x];
    for (int k = 0; k < ML; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      f = s[(s[i] + s[j]) % 256];
      if (lower) enc_mem[g][k] = f ^ lc();
      d = f ^ enc_mem[g][k];
      if (push) exp_wr[g].push_back({5'(k), d});
      if (g == 1 && !(d == 8'h20 || (d >= 8'h61 && d <= 8'h7A))) begin
        if (push) exp_fin[g].push_back(10 * (k + 1) + 1);
        break;
      end
      if (k == ML - 1 && push) exp_fin[g].push_back(1000 + 10 * ML + 1);
    end
    for (int x = 0; x < 256; x++) exp_s[g][x] = s[x];
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input string name, input bit glitch);
    int b = 0, bad;
    fin_cnt[0] = 0;
    fin_cnt[1] = 0;
    @(posedge clk); #1;
    start = 1;
    t0 = cyc;
    while ((fin_cnt[0] == 0 || fin_cnt[1] == 0) && b < 300) begin
      @(posedge clk); #1;
      b++;
      if (glitch && b == 40) start = 0;
      if (glitch && b == 42) start = 1;
    end
    check({name, " timeout"}, int'(b >= 300), 0);
    repeat (30) @(posedge clk);
    #1 start = 0;
    for (int g = 0; g < 2; g++) begin
      bad = 0;
      for (int x = 0; x < 256; x++) bad += int'(s_mem[g][x] !== exp_s[g][x]);
      check($sformatf("%s sram_diffs[%0d]", name, g), bad, 0);
      check($sformatf("%s finished_pulses[%0d]", name, g), fin_cnt[g], 1);
      check($sformatf("%s pending[%0d]", name, g), exp_wr[g].size() + exp_fin[g].size(), 0);
      exp_wr[g].delete();
      exp_fin[g].delete();
    end
  endtask

  initial begin
    logic [7:0] kv_enc[9], pt[9];
    kv_enc = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    load(0);
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check($sformatf("reset_outputs[%0d]", g), int'(outs[g] != 0), 0);
    reset = 0;
    // known vector: key "Key" -> "Plaintext"; the checked instance rejects 'P' at byte 0
    load(2);
    for (int g = 0; g < 2; g++) for (int k = 0; k < ML; k++) enc_mem[g][k] = kv_enc[k];
    plan(0, 0, 0);
    for (int k = 0; k < ML; k++) exp_wr[0].push_back({5'(k), pt[k]});
    exp_fin[0].push_back(1000 + 10 * ML + 1);
    exp_s[1] = s_mem[1];
    exp_s[1][1] = s_mem[1][s_mem[1][1]];
    exp_s[1][s_mem[1][1]] = s_mem[1][1];
    exp_wr[1].push_back({5'd0, 8'h50});
    exp_fin[1].push_back(11);
    run("known_vector", 0);
    // identity S: first byte 0x63 -> 0x61, rest lowercase
    load(0);
    for (int g = 0; g < 2; g++) begin
      plan(g, 1, 0);
      enc_mem[g][0] = 8'h63;
      plan(g, 0, 1);
    end
    check("identity_first_byte", int'(exp_wr[1][0]), int'({5'd0, 8'h61}));
    run("identity", 0);
    // abort at byte 1 on the checked instance
    load(0);
    for (int g = 0; g < 2; g++) begin
      enc_mem[g][0] = 8'h63;
      enc_mem[g][1] = 8'h00;
      plan(g, 0, 1);
    end
    run("abort", 0);
    check("abort_s2", int'(s_mem[1][2]), 3);
    check("abort_s3", int'(s_mem[1][3]), 2);
    // i == j on the first step: S[1] = 1
    load(1);
    for (int g = 0; g < 2; g++) begin
      for (int x = 0; x < 256; x++) if (s_mem[g][x] == 8'd1) begin
        s_mem[g][x] = s_mem[g][1];
        s_mem[g][1] = 8'd1;
      end
      plan(g, 1, 1);
    end
    run("i_eq_j", 0);
    check("i_eq_j_s1", int'(s_mem[0][1]), 1);
    // random images, alternating random and lowercase plaintext
    for (int n = 0; n < 6; n++) begin
      load(1);
      for (int g = 0; g < 2; g++) plan(g, n[0], 1);
      run($sformatf("random%0d", n), 0);
    end
    // second start edge mid-run is ignored
    load(1);
    for (int g = 0; g < 2; g++) plan(g, 1, 1);
    run("second_edge", 1);
    // reset 15 cycles into a run, then a clean run
    load(1);
    for (int g = 0; g < 2; g++) plan(g, 1, 1);
    fin_cnt[0] = 0;
    fin_cnt[1] = 0;
    @(posedge clk); #1;
    start = 1;
    t0 = cyc;
    repeat (15) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("midrun_reset_outputs[%0d]", g), int'(outs[g] != 0), 0);
      check($sformatf("midrun_reset_no_finish[%0d]", g), fin_cnt[g], 0);
      exp_wr[g].delete();
      exp_fin[g].delete();
    end
    start = 0;
    reset = 0;
    load(1);
    for (int g = 0; g < 2; g++) plan(g, 1, 1);
    run("after_reset", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
